mac_cmd_sequencer: RTL and testbench
====================================

MAC_CMD_SEQUENCER -- requirements
Module: mac_cmd_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set op queue depth (power of 2, >=2).
REQ-002 Parameter CNT_W, default 8, SHALL set op_rep width.
REQ-003 Parameter TIMEOUT, default 2048, SHALL set max WAIT cycles per issued command.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 op_valid  in  1  upstream op request.
REQ-007 op_ready  out  1  queue can accept an op.
REQ-008 op_code  in  3  0=sq, 1=sc, 2=mat8, 3=mat16, 4=col_sum, 5-7 illegal.
REQ-009 op_rep  in  CNT_W  times to issue the command; 0 SHALL be treated as 1.
REQ-010 sq, sc, mat8, mat16, col_sum  out  1 each  command pulses to MAC controller.
REQ-011 mac_done  in  1  MAC controller completion, one cycle high.
REQ-012 op_done  out  1  one-cycle pulse when all repetitions of an op complete.
REQ-013 busy  out  1  queue non-empty or FSM not IDLE.
REQ-014 err  out  1  sticky error flag.
REQ-015 err_code  out  2  01 illegal opcode, 10 timeout; holds last error.
REQ-016 clr_err  in  1  synchronous clear of err and err_code.

Function
REQ-017 Handshake SHALL occur when op_valid and op_ready are both high at a rising edge; op_ready = queue not full (no same-cycle pop bypass).
REQ-018 Accepted legal ops SHALL be pushed {op_code, op_rep} in order; illegal opcodes SHALL complete the handshake, not be stored, and set err=1, err_code=01 next cycle.
REQ-019 FSM states: IDLE, ISSUE, WAIT, RETIRE.
REQ-020 IDLE -> ISSUE when queue non-empty; rep_cnt loaded with max(head op_rep,1) on this transition.
REQ-021 ISSUE (one cycle): exactly the command output selected by head op_code SHALL be high; -> WAIT; timeout counter cleared.
REQ-022 WAIT: on mac_done, rep_cnt decrements; -> ISSUE if rep_cnt was >1, else -> RETIRE.
REQ-023 WAIT: if TIMEOUT cycles elapse without mac_done, set err=1, err_code=10, -> RETIRE without op_done.
REQ-024 RETIRE (one cycle): pop head; op_done=1 unless retiring due to timeout; -> ISSUE-path via IDLE rule evaluated next cycle (RETIRE -> IDLE).
REQ-025 Latency: op accepted at edge t into empty queue with FSM IDLE SHALL produce its command pulse in cycle t+2.
REQ-026 Consecutive repetitions SHALL place the next pulse in the cycle immediately after the cycle where mac_done is sampled high.
REQ-027 At most one command output high in any cycle; all command outputs low outside ISSUE.
REQ-028 mac_done outside WAIT SHALL be ignored.
REQ-029 clr_err and a new error in the same cycle: new error wins (err=1, new code).
REQ-030 Push and pop in the same cycle on a non-full queue SHALL both take effect; occupancy unchanged.
REQ-031 Queue pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter range 0..FIFO_DEPTH.

Reset
REQ-032 rst low SHALL immediately empty queue, force FSM to IDLE, clear rep_cnt and timeout counter.
REQ-033 While rst low: op_ready, command outputs, op_done, busy, err =0; err_code=00.
REQ-034 Reset mid-operation SHALL discard pending ops; no pulse or op_done for discarded ops after release.
REQ-035 op_ready SHALL be 1 in the first cycle after rst release.

Verification
REQ-036 Push {code=0, rep=3}, controller model returns mac_done 4 cycles after each pulse -> sq pulses three times, then op_done once; busy low after RETIRE.
REQ-037 Push codes 1,2,3,4 back-to-back (rep=1) -> pulses sc, mat8, mat16, col_sum in order, four op_done pulses; first pulse at cycle t+2.
REQ-038 Push 5 ops with FIFO_DEPTH=4 while first stalls -> op_ready low when 4 queued; fifth accepted only after a RETIRE pop.
REQ-039 Push op_code=6 -> no pulse, queue unchanged, err=1, err_code=01; clr_err -> err=0, err_code=00.
REQ-040 Withhold mac_done for TIMEOUT cycles -> err_code=10, no op_done, next queued op issued.
REQ-041 Assert rst low during WAIT with 2 queued ops -> all outputs 0 immediately; after release no pulses, op_ready=1.

Source files
------------

// File: rtl/mac_cmd_sequencer_if.sv
// Upstream op request channel for the MAC command sequencer.
// Master drives an op (code + repeat count), slave answers with ready.
interface mac_cmd_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_code;
    logic [CNT_W-1:0] op_rep;

    modport master (
        output op_valid,
        output op_code,
        output op_rep,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_code,
        input  op_rep,
        output op_ready
    );
endinterface

// File: rtl/mac_cmd_sequencer.sv
// Queues MAC ops and issues each as repeated one-cycle command pulses,
// waiting for mac_done between pulses, with timeout and error reporting.
module mac_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 2048
) (
    input  logic                clk,
    input  logic                rst,
    mac_cmd_sequencer_if.slave  op,
    output logic                sq,
    output logic                sc,
    output logic                mat8,
    output logic                mat16,
    output logic                col_sum,
    input  logic                mac_done,
    output logic                op_done,
    output logic                busy,
    output logic                err,
    output logic [1:0]          err_code,
    input  logic                clr_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = 3 + CNT_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETIRE} state_t;

    state_t           state, state_nx;
    logic [EW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_nx;
    logic [TW-1:0]    tmo, tmo_nx;
    logic             timed_out, timed_out_nx;
    logic             full, empty, legal, accept, push, pop, tmo_hit;
    logic [2:0]       head_code;
    logic [CNT_W-1:0] head_rep;
    logic [4:0]       cmd;

    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    assign empty       = (count == '0);
    // ready is gated by rst so it reads 0 while reset is held
    assign op.op_ready = rst & ~full;
    assign legal       = (op.op_code <= 3'd4);
    assign accept      = op.op_valid & op.op_ready;
    assign push        = accept & legal;
    assign {head_code, head_rep} = mem[rd_ptr];

    assign {col_sum, mat16, mat8, sc, sq} = cmd;
    assign busy = ~empty | (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {op.op_code, op.op_rep};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rep_cnt   <= '0;
            tmo       <= '0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_nx;
            rep_cnt   <= rep_cnt_nx;
            tmo       <= tmo_nx;
            timed_out <= timed_out_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        rep_cnt_nx   = rep_cnt;
        tmo_nx       = tmo;
        timed_out_nx = timed_out;
        cmd          = '0;
        op_done      = 1'b0;
        pop          = 1'b0;
        tmo_hit      = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nx     = ISSUE;
                    rep_cnt_nx   = (head_rep == '0) ? CNT_W'(1) : head_rep;
                    timed_out_nx = 1'b0;
                end
            end
            ISSUE: begin
                cmd      = 5'd1 << head_code;
                tmo_nx   = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                if (mac_done) begin
                    rep_cnt_nx = rep_cnt - 1'b1;
                    state_nx   = (rep_cnt > CNT_W'(1)) ? ISSUE : RETIRE;
                end else if (tmo == TW'(TIMEOUT - 1)) begin
                    tmo_hit      = 1'b1;
                    timed_out_nx = 1'b1;
                    state_nx     = RETIRE;
                end else begin
                    tmo_nx = tmo + 1'b1;
                end
            end
            RETIRE: begin
                pop      = 1'b1;
                op_done  = ~timed_out;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // a fresh error outranks a clear arriving in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err      <= 1'b0;
            err_code <= 2'b00;
        end else if (tmo_hit) begin
            err      <= 1'b1;
            err_code <= 2'b10;
        end else if (accept && !legal) begin
            err      <= 1'b1;
            err_code <= 2'b01;
        end else if (clr_err) begin
            err      <= 1'b0;
            err_code <= 2'b00;
        end
    end
endmodule

// File: tb/tb_mac_cmd_sequencer.sv
// Directed bench for mac_cmd_sequencer with a queue-based scoreboard
// and a simple MAC controller model answering each command pulse.
module tb_mac_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int CW    = 8;
    localparam int TMO   = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mac_done = 1'b0;
    logic       clr_err = 1'b0;
    logic       sq, sc, mat8, mat16, col_sum;
    logic       op_done, busy, err;
    logic [1:0] err_code;

    mac_cmd_sequencer_if #(.CNT_W(CW)) ifc ();

    mac_cmd_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .op       (ifc),
        .sq       (sq),
        .sc       (sc),
        .mat8     (mat8),
        .mat16    (mat16),
        .col_sum  (col_sum),
        .mac_done (mac_done),
        .op_done  (op_done),
        .busy     (busy),
        .err      (err),
        .err_code (err_code),
        .clr_err  (clr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;
    int dly = 4;
    int skip = 0;
    int mcnt = 0;
    int exp_cmd[$];
    bit exp_done[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [4:0] cmds();
        return {col_sum, mat16, mat8, sc, sq};
    endfunction

    function automatic int cmd_idx();
        if (sq)    return 0;
        if (sc)    return 1;
        if (mat8)  return 2;
        if (mat16) return 3;
        return 4;
    endfunction

    // scoreboard monitor
    initial forever begin
        @(negedge clk);
        if (cmds() != 5'd0) begin
            check("cmd_onehot", $countones(cmds()), 1);
            if (exp_cmd.size() == 0) check("cmd_unexpected", cmds(), 0);
            else check("cmd_order", cmd_idx(), exp_cmd.pop_front());
        end
        if (op_done) begin
            done_seen++;
            if (exp_done.size() == 0) check("done_unexpected", op_done, 0);
            else void'(exp_done.pop_front());
        end
    end

    // MAC controller model: mac_done dly cycles after each pulse
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            mac_done = 1'b0;
            mcnt = 0;
        end else begin
            mac_done = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) mac_done = 1'b1;
            end
            if (cmds() != 5'd0) begin
                if (skip > 0) skip--;
                else mcnt = dly;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_op(input logic [2:0] c, input logic [CW-1:0] r,
                           input int n, input bit d);
        int k = 0;
        while (ifc.op_ready !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("ready_timeout", ifc.op_ready, 1);
        for (int i = 0; i < n; i++) exp_cmd.push_back(int'(c));
        if (d) exp_done.push_back(1'b1);
        ifc.op_valid = 1'b1;
        ifc.op_code  = c;
        ifc.op_rep   = r;
        @(posedge clk);
        @(negedge clk);
        ifc.op_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(name, busy, 0);
    endtask

    initial begin
        int d0;
        int t0;
        int k;
        ifc.op_valid = 1'b0;
        ifc.op_code  = '0;
        ifc.op_rep   = '0;

        repeat (3) @(negedge clk);
        check("rst_ready", ifc.op_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
        check("rst_cmds", cmds(), 0);
        check("rst_done", op_done, 0);
        rst = 1'b1;
        #1;
        check("ready_after_rst", ifc.op_ready, 1);
        @(negedge clk);

        // sq x3 with latency check on first pulse
        d0 = done_seen;
        push_op(3'd0, 8'd3, 3, 1'b1);
        @(negedge clk);
        check("latency_sq", sq, 1);
        wait_idle("idle_sq3");
        check("done_sq3", done_seen - d0, 1);

        // rep=0 behaves as one repetition
        d0 = done_seen;
        push_op(3'd2, 8'd0, 1, 1'b1);
        wait_idle("idle_rep0");
        check("done_rep0", done_seen - d0, 1);

        // back-to-back sc, mat8, mat16, col_sum
        d0 = done_seen;
        for (int c = 1; c <= 4; c++) push_op(3'(c), 8'd1, 1, 1'b1);
        wait_idle("idle_b2b");
        check("done_b2b", done_seen - d0, 4);

        // fill queue while head stalls
        dly = 12;
        d0 = done_seen;
        for (int i = 0; i < 4; i++) push_op(3'd0, 8'd1, 1, 1'b1);
        check("full_ready", ifc.op_ready, 0);
        check("full_no_done", done_seen - d0, 0);
        push_op(3'd1, 8'd1, 1, 1'b1);
        check("fifth_after_retire", (done_seen - d0) >= 1, 1);
        wait_idle("idle_full");
        check("done_full", done_seen - d0, 5);
        dly = 4;

        // illegal opcode
        push_op(3'd6, 8'd1, 0, 1'b0);
        check("illegal_err", err, 1);
        check("illegal_code", err_code, 2'b01);
        check("illegal_busy", busy, 0);
        check("illegal_ready", ifc.op_ready, 1);
        repeat (4) @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err", err, 0);
        check("clr_code", err_code, 0);

        // timeout on first op, second still issued
        skip = 1;
        d0 = done_seen;
        push_op(3'd3, 8'd1, 1, 1'b0);
        @(negedge clk);
        check("latency_mat16", mat16, 1);
        t0 = cyc;
        push_op(3'd4, 8'd1, 1, 1'b1);
        k = 0;
        while (!err && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", cyc - t0, TMO + 1);
        check("timeout_code", err_code, 2'b10);
        wait_idle("idle_timeout");
        check("timeout_done", done_seen - d0, 1);
        check("timeout_sticky", err, 1);

        // clear and new error in the same cycle
        clr_err = 1'b1;
        push_op(3'd7, 8'd1, 0, 1'b0);
        clr_err = 1'b0;
        check("clr_vs_new_err", err, 1);
        check("clr_vs_new_code", err_code, 2'b01);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err2", err, 0);

        // reset while waiting with two ops queued
        skip = 5;
        push_op(3'd0, 8'd1, 1, 1'b0);
        push_op(3'd1, 8'd1, 0, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("midrst_ready", ifc.op_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_cmds", cmds(), 0);
        check("midrst_done", op_done, 0);
        check("midrst_err", err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        skip = 0;
        #1;
        check("post_rst_ready", ifc.op_ready, 1);
        repeat (20) @(negedge clk);
        check("post_rst_busy", busy, 0);

        check("cmd_queue_empty", exp_cmd.size(), 0);
        check("done_queue_empty", exp_done.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
